// File: rtl/ahb_bram_ctrl.sv
// ahb_bram_ctrl: AHB-Lite slave bridging to a simple dual-port 32-bit BRAM.
//   Writes complete on the BRAM A port at the end of the AHB write data phase.
//   Reads are issued on the B port during the address phase, so they return
//   with zero wait states.
//   A read of the word written in the immediately preceding cycle (RAW hazard)
//   is handled in one of two ways:
//     - default: one wait state (STALL) while the word is re-read;
//     - with `AHB_BRAM_RAW_FWD_EN defined: the write data is forwarded
//       byte-wise, with no wait state.
// Ports:
//   HCLK, HRESETn             clock, asynchronous active-low reset
//   HSEL..HREADY (inputs)     AHB-Lite slave address/data-phase inputs
//   HREADYOUT, HRDATA, HRESP  AHB-Lite slave responses (HRESP always OKAY)
//   addra, dina, wea          BRAM write port (byte enables)
//   addrb, doutb              BRAM read port (one-cycle registered read)
module ahb_bram_ctrl #(
  parameter int unsigned ADDR_WIDTH = 13
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic [31:0]           HRDATA,
  output logic                  HRESP,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic [31:0]           dina,
  output logic [3:0]            wea,
  output logic [ADDR_WIDTH-1:0] addrb,
  input  logic [31:0]           doutb
);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_STALL} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [3:0]              strb_q, strb_d;
  logic [ADDR_WIDTH-1:0]   idx_c;
  logic [3:0]              strb_c;
  logic                    accept_c;
  logic                    hazard_c;
  logic                    unused_c;

`ifdef AHB_BRAM_RAW_FWD_EN
  logic [31:0]             fwd_data_q, fwd_data_d;
  logic [3:0]              fwd_strb_q, fwd_strb_d;
`else
  logic [ADDR_WIDTH-1:0]   rd_idx_q, rd_idx_d;
`endif

  // Upper address bits alias; HTRANS[0] only separates NONSEQ from SEQ.
  assign unused_c = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

  assign idx_c    = HADDR[ADDR_WIDTH+1:2];
  // The STALL term keeps the bridge from accepting a transfer while it holds
  // HREADYOUT low, even if the interconnect drives HREADY high.
  assign accept_c = HSEL & HREADY & HTRANS[1] & (state_q != S_STALL);
  // The read targets the word that the BRAM writes at this same edge.
  assign hazard_c = accept_c & ~HWRITE & (state_q == S_WR) & (idx_c == addr_q);

  // Byte lane strobes for the transfer in its address phase
  always_comb begin
    strb_c = 4'b1111;
    case (HSIZE)
      3'd0:    strb_c = 4'b0001 << HADDR[1:0];
      3'd1:    strb_c = HADDR[1] ? 4'b1100 : 4'b0011;
      default: strb_c = 4'b1111;
    endcase
  end

  // Next-state logic and outputs
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    strb_d    = strb_q;
    HREADYOUT = 1'b1;
    HRDATA    = 32'h0;
    HRESP     = 1'b0;
    addra     = addr_q;
    dina      = HWDATA;
    wea       = 4'b0000;
    addrb     = idx_c;
`ifdef AHB_BRAM_RAW_FWD_EN
    // Forwarding bytes apply only to the RD phase right after a hazard.
    fwd_data_d = hazard_c ? HWDATA : fwd_data_q;
    fwd_strb_d = hazard_c ? strb_q : 4'b0000;
`else
    rd_idx_d   = rd_idx_q;
`endif

    if (accept_c) begin
      addr_d = idx_c;
      strb_d = strb_c;
`ifndef AHB_BRAM_RAW_FWD_EN
      if (!HWRITE) rd_idx_d = idx_c;
`endif
    end

    case (state_q)
      S_STALL: begin
        HREADYOUT = 1'b0;
`ifndef AHB_BRAM_RAW_FWD_EN
        // Re-read the word now that the colliding write has landed.
        addrb     = rd_idx_q;
`endif
        state_d   = S_RD;
      end
      default: begin
        if (state_q == S_WR) wea = strb_q;
        if (state_q == S_RD) begin
`ifdef AHB_BRAM_RAW_FWD_EN
          for (int b = 0; b < 4; b++)
            HRDATA[b*8 +: 8] = fwd_strb_q[b] ? fwd_data_q[b*8 +: 8] : doutb[b*8 +: 8];
`else
          HRDATA = doutb;
`endif
        end
        if (!accept_c)    state_d = S_IDLE;
        else if (HWRITE)  state_d = S_WR;
`ifdef AHB_BRAM_RAW_FWD_EN
        else              state_d = S_RD;
`else
        else if (hazard_c) state_d = S_STALL;
        else              state_d = S_RD;
`endif
      end
    endcase
  end

  // State and transfer registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      strb_q     <= 4'b0000;
`ifdef AHB_BRAM_RAW_FWD_EN
      fwd_data_q <= 32'h0;
      fwd_strb_q <= 4'b0000;
`else
      rd_idx_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      strb_q     <= strb_d;
`ifdef AHB_BRAM_RAW_FWD_EN
      fwd_data_q <= fwd_data_d;
      fwd_strb_q <= fwd_strb_d;
`else
      rd_idx_q   <= rd_idx_d;
`endif
    end
  end

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Scoreboard bench for ahb_bram_ctrl with a behavioural read-first BRAM.
module tb_ahb_bram_ctrl;
  localparam int unsigned AW = 13;
`ifdef AHB_BRAM_RAW_FWD_EN
  localparam logic [31:0] HZW = 32'd0;
`else
  localparam logic [31:0] HZW = 32'd1;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] waits;
  } rd_exp_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [3:0]    wea;
    logic [31:0]   dina;
  } wr_exp_t;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic          HWRITE;
  logic [31:0]   HWDATA;
  logic          HREADYOUT;
  logic [31:0]   HRDATA;
  logic          HRESP;
  logic [AW-1:0] addra;
  logic [31:0]   dina;
  logic [3:0]    wea;
  logic [AW-1:0] addrb;
  logic [31:0]   doutb;

  logic [31:0]   mem [0:(1<<AW)-1];

  rd_exp_t rq[$];
  wr_exp_t wq[$];
  int total = 0;
  int bad   = 0;

  always #5 HCLK = ~HCLK;

  ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HREADY(HREADYOUT), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP),
    .addra(addra), .dina(dina), .wea(wea), .addrb(addrb), .doutb(doutb)
  );

  // Read-first BRAM with byte enables and a registered read port
  initial for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
  always @(posedge HCLK) begin
    for (int b = 0; b < 4; b++)
      if (wea[b]) mem[addra][b*8 +: 8] <= dina[b*8 +: 8];
    doutb <= mem[addrb];
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Monitor: compares BRAM writes and completed read data phases
  initial begin : monitor
    logic    dph;
    int      waits;
    rd_exp_t r;
    wr_exp_t w;
    dph   = 1'b0;
    waits = 0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        dph   = 1'b0;
        waits = 0;
      end else begin
        check("hresp", 32'(HRESP), 32'd0);
        if (wea != 4'b0000) begin
          if (wq.size() == 0) check("unexpected_write", 32'(wea), 32'd0);
          else begin
            w = wq.pop_front();
            check("wea", 32'(wea), 32'(w.wea));
            check("addra", 32'(addra), 32'(w.addr));
            check("dina", dina, w.dina);
          end
        end
        if (dph) begin
          if (HREADYOUT) begin
            if (rq.size() == 0) check("unexpected_read", HRDATA, 32'hFFFF_FFFF);
            else begin
              r = rq.pop_front();
              check("hrdata", HRDATA, r.data);
              check("wait_states", 32'(waits), r.waits);
            end
            dph = 1'b0;
          end else waits++;
        end else check("hrdata_idle", HRDATA, 32'h0);
        if (HREADYOUT) begin
          dph   = HSEL && HTRANS[1] && !HWRITE;
          waits = 0;
        end
      end
    end
  end

  // One bus cycle: present an address phase plus data for the previous
  // transfer, and hold both until the slave is ready.
  task automatic cyc(input logic [1:0] trans, input logic wr, input logic [31:0] addr,
                     input logic [2:0] size, input logic [31:0] wdata);
    int   n;
    logic rdy;
    HSEL   = (trans != 2'b00);
    HTRANS = trans;
    HWRITE = wr;
    HADDR  = addr;
    HSIZE  = size;
    HWDATA = wdata;
    n      = 0;
    do begin
      @(negedge HCLK);
      rdy = HREADYOUT;
      @(posedge HCLK);
      #1;
      n++;
    end while (!rdy && n < 8);
    if (!rdy) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got=0 expected=1 at addr %h", addr);
    end
  endtask

  task automatic idle(input logic [31:0] wdata);
    cyc(2'b00, 1'b0, 32'h0, 3'd0, wdata);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    HRESETn = 1'b0;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    HADDR = 32'h0; HSIZE = 3'd0; HWDATA = 32'h0;
    repeat (2) @(posedge HCLK);
    #1;
    check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    check("rst_hrdata", HRDATA, 32'h0);
    check("rst_wea", 32'(wea), 32'd0);
    check("rst_addra", 32'(addra), 32'd0);
    check("rst_hresp", 32'(HRESP), 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    // Word write then read
    wq.push_back('{13'd4, 4'hF, 32'hDEADBEEF});
    cyc(2'b10, 1'b1, 32'h10, 3'd2, 32'h0);
    idle(32'hDEADBEEF);
    rq.push_back('{32'hDEADBEEF, 32'd0});
    cyc(2'b10, 1'b0, 32'h10, 3'd2, 32'h0);
    idle(32'h0);

    // Back-to-back word write then byte write to lane 3
    wq.push_back('{13'd4, 4'hF, 32'h11223344});
    wq.push_back('{13'd4, 4'b1000, 32'hAA000000});
    cyc(2'b10, 1'b1, 32'h10, 3'd2, 32'h0);
    cyc(2'b10, 1'b1, 32'h13, 3'd0, 32'h11223344);
    idle(32'hAA000000);
    rq.push_back('{32'hAA223344, 32'd0});
    cyc(2'b10, 1'b0, 32'h10, 3'd2, 32'h0);
    idle(32'h0);

    // Halfword write to the upper half
    wq.push_back('{13'd8, 4'b1100, 32'h55660000});
    cyc(2'b10, 1'b1, 32'h22, 3'd1, 32'h0);
    idle(32'h55660000);
    rq.push_back('{32'h55660000, 32'd0});
    cyc(2'b10, 1'b0, 32'h20, 3'd2, 32'h0);
    idle(32'h0);

    // RAW hazard: word write immediately followed by read of the same word
    wq.push_back('{13'd16, 4'hF, 32'hCAFEF00D});
    rq.push_back('{32'hCAFEF00D, HZW});
    cyc(2'b10, 1'b1, 32'h40, 3'd2, 32'h0);
    cyc(2'b10, 1'b0, 32'h40, 3'd2, 32'hCAFEF00D);
    idle(32'h0);

    // RAW hazard with a partial (lower halfword) write
    wq.push_back('{13'd16, 4'b0011, 32'h0000BEEF});
    rq.push_back('{32'hCAFEBEEF, HZW});
    cyc(2'b10, 1'b1, 32'h40, 3'd1, 32'h0);
    cyc(2'b10, 1'b0, 32'h40, 3'd2, 32'h0000BEEF);
    idle(32'h0);

    // Read-read, read-write, write-read to different words
    rq.push_back('{32'hAA223344, 32'd0});
    rq.push_back('{32'h55660000, 32'd0});
    rq.push_back('{32'hCAFEBEEF, 32'd0});
    wq.push_back('{13'd17, 4'hF, 32'h01020304});
    cyc(2'b10, 1'b0, 32'h10, 3'd2, 32'h0);
    cyc(2'b10, 1'b0, 32'h20, 3'd2, 32'h0);
    cyc(2'b10, 1'b0, 32'h40, 3'd2, 32'h0);
    cyc(2'b10, 1'b1, 32'h44, 3'd2, 32'h0);
    wq.push_back('{13'd18, 4'hF, 32'h0BADF00D});
    rq.push_back('{32'h01020304, 32'd0});
    cyc(2'b10, 1'b1, 32'h48, 3'd2, 32'h01020304);
    cyc(2'b10, 1'b0, 32'h44, 3'd2, 32'h0BADF00D);
    idle(32'h0);

    // BUSY transfer must be ignored
    cyc(2'b01, 1'b1, 32'h10, 3'd2, 32'h0);
    idle(32'h99999999);
    rq.push_back('{32'hAA223344, 32'd0});
    cyc(2'b10, 1'b0, 32'h10, 3'd2, 32'h0);
    idle(32'h0);

    // Address aliasing: 0x8004 lands on word 1
    wq.push_back('{13'd1, 4'hF, 32'h77777777});
    cyc(2'b10, 1'b1, 32'h00008004, 3'd2, 32'h0);
    idle(32'h77777777);
    rq.push_back('{32'h77777777, 32'd0});
    cyc(2'b10, 1'b0, 32'h4, 3'd2, 32'h0);
    idle(32'h0);

    // Reset during the write data phase aborts the write
    cyc(2'b10, 1'b1, 32'h80, 3'd2, 32'h0);
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h12345678;
    HRESETn = 1'b0;
    #1;
    check("rstwr_wea", 32'(wea), 32'd0);
    check("rstwr_hreadyout", 32'(HREADYOUT), 32'd1);
    check("rstwr_addra", 32'(addra), 32'd0);
    @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    rq.push_back('{32'h00000000, 32'd0});
    cyc(2'b10, 1'b0, 32'h80, 3'd2, 32'h0);
    idle(32'h0);

    repeat (3) @(posedge HCLK);
    #1;
    check("rd_queue_left", 32'(rq.size()), 32'd0);
    check("wr_queue_left", 32'(wq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_bram_ctrl.md
AHB_BRAM_CTRL -- requirements
Module: ahb_bram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 13: BRAM word-address width (2**ADDR_WIDTH x 32-bit words).
REQ-002 SHALL have port HCLK  in  1: single clock; all state on its rising edge.
REQ-003 SHALL have port HRESETn  in  1: asynchronous active-low reset.
REQ-004 SHALL have ports HSEL in 1, HADDR in 32, HTRANS in 2, HSIZE in 3, HWRITE in 1, HWDATA in 32, HREADY in 1: AHB-Lite slave inputs.
REQ-005 SHALL have ports HREADYOUT out 1, HRDATA out 32, HRESP out 1: AHB-Lite slave outputs.
REQ-006 SHALL have ports addra out ADDR_WIDTH, dina out 32, wea out 4: BRAM write port (write at HCLK edge when any wea bit set).
REQ-007 SHALL have ports addrb out ADDR_WIDTH, doutb in 32: BRAM read port, one-cycle registered read latency.

Function
REQ-008 SHALL accept a transfer when HSEL & HREADY & HTRANS[1] at an HCLK edge; IDLE/BUSY transfers ignored.
REQ-009 SHALL use word index HADDR[ADDR_WIDTH+1:2]; higher HADDR bits ignored (address aliasing).
REQ-010 SHALL derive byte strobes at accept: HSIZE=0 -> 4'b0001<<HADDR[1:0]; HSIZE=1 -> HADDR[1]?4'b1100:4'b0011; HSIZE>=2 -> 4'b1111.
REQ-011 SHALL implement FSM IDLE, WR, RD, STALL; accepted write -> WR, accepted read -> RD, no accept -> IDLE, all from IDLE/WR/RD.
REQ-012 SHALL, in WR, drive addra=registered word index, wea=registered strobes, dina=HWDATA, so BRAM writes at end of the write data phase; wea=0 in every other state.
REQ-013 SHALL drive addrb combinationally from HADDR word index in the address phase of every cycle except STALL, where addrb=registered read index.
REQ-014 SHALL, in RD with no hazard, drive HRDATA=doutb and HREADYOUT=1 (zero wait states).
REQ-015 SHALL detect a RAW hazard: read accepted while the FSM is in WR with equal word index.
REQ-016 SHALL drive HRESP=0 (OKAY) at all times; HREADYOUT=1 in IDLE, WR, RD.
REQ-017 SHALL drive HRDATA=0 outside RD/STALL data phases.
REQ-018 SHALL handle back-to-back write-write, read-read, read-write, write-read with no wait states except as per REQ-026.
REQ-019 SHALL not accept a new transfer while HREADYOUT=0 (HREADY low); address-phase signals held by master.

Reset
REQ-020 SHALL, on HRESETn low, immediately force FSM=IDLE, HREADYOUT=1, HRDATA=0, wea=0, addra=0, registered indices/strobes/forward data=0.
REQ-021 SHALL abort any pending WR/STALL on reset mid-transfer; no BRAM write occurs while HRESETn low.
REQ-022 SHALL resume accepting transfers on the first HCLK edge after HRESETn deasserts.

Configuration
REQ-023 SHALL gate RAW forwarding with macro AHB_BRAM_RAW_FWD_EN.
REQ-024 SHALL, with AHB_BRAM_RAW_FWD_EN defined, register the colliding write's HWDATA and strobes and, in the following RD, output HRDATA byte-wise = strobe ? forwarded byte : doutb byte, zero wait states; STALL unreachable.
REQ-025 SHALL, with AHB_BRAM_RAW_FWD_EN undefined, on hazard enter STALL instead of RD.
REQ-026 SHALL, in STALL, hold HREADYOUT=0 one cycle re-reading registered index, then go to RD and return doutb with HREADYOUT=1 (one wait state).

Verification
REQ-027 SHALL cover: word write 0xDEADBEEF to 0x10, later read 0x10 -> HRDATA=0xDEADBEEF, HREADYOUT never low.
REQ-028 SHALL cover: byte write 0xAA at 0x13 over word 0x11223344 -> wea=4'b1000 in WR; read 0x10 -> 0xAA223344.
REQ-029 SHALL cover: halfword write 0x5566 at 0x22 -> wea=4'b1100, dina upper half 0x5566; read -> bits[31:16]=0x5566.
REQ-030 SHALL cover: write 0xCAFEF00D to 0x40 then immediate read 0x40 -> with macro 0xCAFEF00D zero-wait; without macro HREADYOUT low exactly 1 cycle then 0xCAFEF00D.
REQ-031 SHALL cover: HRESETn pulsed low during WR of 0x12345678 to 0x80 over 0x0 -> wea=0, read 0x80 returns 0x00000000, HREADYOUT=1 after reset.
REQ-032 SHALL cover: HADDR 0x00008004 with ADDR_WIDTH=13 -> aliases to word 1 (addra=1).
